// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forward-select codes, shadow-stage records, forward decode helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // What the controller remembers about an instruction occupying a later stage.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
      logic              reg_write;
      logic              mem_read;
   } stage_t;

   // EX also keeps its sources so its operand muxes can be steered.
   typedef struct packed {
      stage_t            base;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              uses_rs;
      logic              uses_rt;
   } ex_stage_t;

   // One operand's forward select. MEM wins over WB; a load in MEM has no
   // data yet at the EX/MEM ALU tap, so it is never a MEM forwarding source.
   // $0 is hardwired, so it never forwards.
   function automatic logic [1:0] fwd_select(input logic              qual,
                                             input logic [REG_AW-1:0] src,
                                             input stage_t            mem,
                                             input stage_t            wb);
      logic [1:0] sel;
      sel = FWD_REG;
      if (qual && (src != '0)) begin
         if (mem.valid && mem.reg_write && !mem.mem_read && (mem.dst == src))
            sel = FWD_MEM;
         else if (wb.valid && wb.reg_write && (wb.dst == src))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy: down-counter loaded with MD_LATENCY on issue, busy while nonzero.
// Latency: busy rises the cycle after the issuing edge and stays high MD_LATENCY cycles.
// Backpressure: none; consumers interlock on busy.
module md_busy_counter #(
   parameter int MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic busy
);

   localparam int            CW       = $clog2(MD_LATENCY + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY);

   logic [CW-1:0] count;

   // Reload on issue, otherwise drain toward zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= LOAD_VAL;
      else if (count != '0)
         count <= count - CW'(1);
   end

   assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage pipeline: forward selects, load-use stall, branch flush, MD interlock.
// Latency: forwards decoded from registered shadow state; stall/bubble/flush combinational from ID the same cycle.
// Backpressure: stall_if_id holds PC and IF/ID; bubble_ex injects a NOP into ID/EX.
module hazard_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int REG_AW     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_md_start,
   input  logic              id_md_read,
   input  logic              ex_branch_taken,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall_if_id,
   output logic              bubble_ex,
   output logic              flush_if_id,
   output logic              md_busy
);

   import cpu_pkg::*;

   ex_stage_t ex_q;
   stage_t    mem_q;
   stage_t    wb_q;

   logic load_use;
   logic md_wait;
   logic br_kill;
   logic md_load;

   // Operand selects depend only on registered shadow state, never on ID inputs.
   always_comb begin
      forward_a = fwd_select(ex_q.base.valid & ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
      forward_b = fwd_select(ex_q.base.valid & ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
   end

   // Stall/flush arbitration; a taken branch kills ID, so it overrides both stalls.
   // A branch can only resolve with a real instruction in EX, which also keeps
   // these outputs quiet in the cycle right after reset.
   always_comb begin
      load_use = id_valid & ex_q.base.valid & ex_q.base.mem_read & (ex_q.base.dst != '0) &
                 ((id_uses_rs & (id_rs == ex_q.base.dst)) |
                  (id_uses_rt & (id_rt == ex_q.base.dst)));
      md_wait     = md_busy & id_valid & (id_md_read | id_md_start);
      br_kill     = ex_branch_taken & ex_q.base.valid;
      flush_if_id = br_kill;
      bubble_ex   = br_kill | load_use | md_wait;
      stall_if_id = ~br_kill & (load_use | md_wait);
      md_load     = id_valid & id_md_start & ~bubble_ex;
   end

   // Shadow pipeline: advances every cycle; EX takes ID unless a bubble is injected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q.base;
         if (bubble_ex) begin
            ex_q.base.valid <= 1'b0;
         end else begin
            ex_q.base.valid     <= id_valid;
            ex_q.base.dst       <= id_dst;
            ex_q.base.reg_write <= id_reg_write;
            ex_q.base.mem_read  <= id_mem_read;
            ex_q.rs             <= id_rs;
            ex_q.rt             <= id_rt;
            ex_q.uses_rs        <= id_uses_rs;
            ex_q.uses_rt        <= id_uses_rt;
         end
      end
   end

   md_busy_counter #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_busy (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (md_load),
      .busy  (md_busy)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, reset corner sequences, random run vs. pipeline model.
// Latency: inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

   localparam int L = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic       id_md_start, id_md_read, ex_branch_taken;
   logic [4:0] id_rs, id_rt, id_dst;
   logic [1:0] forward_a, forward_b;
   logic       stall_if_id, bubble_ex, flush_if_id, md_busy;

   always #5 clk = ~clk;

   hazard_ctrl #(.MD_LATENCY(L), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_md_start(id_md_start),
      .id_md_read(id_md_read), .ex_branch_taken(ex_branch_taken),
      .forward_a(forward_a), .forward_b(forward_b), .stall_if_id(stall_if_id),
      .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .md_busy(md_busy));

   typedef struct {
      bit idv; int rs; int rt; bit urs; bit urt; int dst; bit rw; bit mr; bit mds; bit mdr; bit br;
      int fa; int fb; bit st; bit bu; bit fl; bit busy;
   } vec_t;

   // Model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct { bit v; bit rw; bit mr; bit urs; bit urt; int dst; int rs; int rt; } ins_t;
   ins_t pipe[3];
   int   md_left;

   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[25];

   function automatic vec_t mk(bit idv, int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr,
                               bit mds, bit mdr, bit br, int fa, int fb, bit st, bit bu, bit fl, bit busy);
      vec_t r;
      r.idv = idv; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dst = dst; r.rw = rw; r.mr = mr;
      r.mds = mds; r.mdr = mdr; r.br = br; r.fa = fa; r.fb = fb; r.st = st; r.bu = bu; r.fl = fl;
      r.busy = busy;
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      md_left = 0;
   endfunction

   function automatic int m_fwd(int src, bit uses);
      if (!pipe[0].v || !uses || src == 0) return 0;
      if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].dst == src) return 2;
      if (pipe[2].v && pipe[2].rw && pipe[2].dst == src) return 1;
      return 0;
   endfunction

   function automatic vec_t model_expect(vec_t r);
      vec_t e;
      bit lu, md, brk;
      e   = r;
      lu  = r.idv && pipe[0].v && pipe[0].mr && pipe[0].dst != 0 &&
            ((r.urs && r.rs == pipe[0].dst) || (r.urt && r.rt == pipe[0].dst));
      md  = (md_left > 0) && r.idv && (r.mdr || r.mds);
      brk = r.br && pipe[0].v;
      e.fl = brk;
      e.bu = brk || lu || md;
      e.st = !brk && (lu || md);
      e.fa = m_fwd(pipe[0].rs, pipe[0].urs);
      e.fb = m_fwd(pipe[0].rt, pipe[0].urt);
      e.busy = (md_left > 0);
      return e;
   endfunction

   function automatic void model_advance(vec_t r, bit bubble);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (bubble) pipe[0].v = 1'b0;
      else begin
         pipe[0].v = r.idv; pipe[0].rw = r.rw; pipe[0].mr = r.mr; pipe[0].dst = r.dst;
         pipe[0].rs = r.rs; pipe[0].rt = r.rt; pipe[0].urs = r.urs; pipe[0].urt = r.urt;
      end
      if (r.idv && r.mds && !bubble) md_left = L;
      else if (md_left > 0) md_left--;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(vec_t r);
      id_valid = r.idv; id_rs = 5'(r.rs); id_rt = 5'(r.rt); id_uses_rs = r.urs; id_uses_rt = r.urt;
      id_dst = 5'(r.dst); id_reg_write = r.rw; id_mem_read = r.mr; id_md_start = r.mds;
      id_md_read = r.mdr; ex_branch_taken = r.br;
   endtask

   task automatic compare(string tag, vec_t e);
      chk({tag, ".forward_a"}, int'(forward_a), e.fa);
      chk({tag, ".forward_b"}, int'(forward_b), e.fb);
      chk({tag, ".stall_if_id"}, int'(stall_if_id), int'(e.st));
      chk({tag, ".bubble_ex"}, int'(bubble_ex), int'(e.bu));
      chk({tag, ".flush_if_id"}, int'(flush_if_id), int'(e.fl));
      chk({tag, ".md_busy"}, int'(md_busy), int'(e.busy));
   endtask

   task automatic run_cycle(vec_t r, bit use_tbl, string tag);
      vec_t e;
      @(posedge clk);
      #1 drive(r);
      @(negedge clk);
      e = model_expect(r);
      if (use_tbl) compare(tag, r);
      else compare(tag, e);
      model_advance(r, e.bu);
   endtask

   task automatic check_zero(string tag);
      compare(tag, mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
   endtask

   // Asynchronous reset from the middle of a cycle, with ID inputs still held.
   task automatic async_reset(string tag);
      #1 rst_n = 1'b0;
      #1 check_zero(tag);
      drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      vec_t nop, r;
      nop = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
      //           idv rs rt us ut dst rw mr mds mdr br   fa fb st bu fl busy
      tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0); // add $3,$1,$2
      tbl[1]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // sub $4,$3,$5
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0); // sub in EX: MEM fwd
      tbl[3]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // add $3
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // nop gap
      tbl[5]  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // sub $4,$3,$5
      tbl[6]  = mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0); // sub in EX: WB fwd; lw in ID
      tbl[7]  = mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0); // add $4,$3,$3: load-use
      tbl[8]  = mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // single bubble only
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0); // add in EX: WB fwd both
      tbl[10] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // writes $0
      tbl[11] = mk(1, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // writes $0
      tbl[12] = mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // reads $0,$0
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // $0 never forwards
      tbl[14] = mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0); // div
      tbl[15] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1); // mflo stalls
      tbl[16] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1);
      tbl[17] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1);
      tbl[18] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1);
      tbl[19] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0); // mflo advances
      tbl[20] = mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // lw $7
      tbl[21] = mk(1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0); // load-use + branch
      tbl[22] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      tbl[23] = mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0); // div killed by branch
      tbl[24] = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0); // mfhi: no MD busy

      rst_n = 1'b0;
      drive(nop);
      model_reset();
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 25; i++) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Reset in the middle of a load-use stall.
      run_cycle(mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0,0,0,0,0,0), 1'b0, "lu_lw");
      run_cycle(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0,0,0,0,0,0), 1'b0, "lu_add");
      chk("lu_stall_before_reset", int'(stall_if_id), 1);
      async_reset("rst_mid_stall");
      run_cycle(mk(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0,0,0,0,0,0), 1'b0, "after_rst_stall");

      // Reset with the MD counter at 2.
      run_cycle(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0,0,0,0,0,0), 1'b0, "md_div");
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0, $sformatf("md_nop%0d", i));
      chk("md_busy_before_reset", int'(md_busy), 1);
      async_reset("rst_mid_md");
      run_cycle(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0, 0,0,0,0,0,0), 1'b0, "mfhi_after_rst");
      chk("mfhi_after_rst_no_stall", int'(stall_if_id), 0);

      // Random traffic against the model; a narrow register range makes hazards frequent.
      for (int i = 0; i < 400; i++) begin
         r = nop;
         r.idv = ($urandom_range(0, 7) != 0);
         r.rs  = $urandom_range(0, 3);
         r.rt  = $urandom_range(0, 3);
         r.dst = $urandom_range(0, 3);
         r.urs = $urandom_range(0, 1);
         r.urt = $urandom_range(0, 1);
         r.rw  = ($urandom_range(0, 3) != 0);
         r.mr  = ($urandom_range(0, 3) == 0);
         r.mds = ($urandom_range(0, 15) == 0);
         r.mdr = ($urandom_range(0, 7) == 0);
         r.br  = ($urandom_range(0, 7) == 0);
         run_cycle(r, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
